// File: rtl/minimal_onchip_loader_if.sv
// Byte-stream handshake and single-port memory bus for the on-chip loader.
// The master modport is the loader's view; slave is the source/memory side.
interface minimal_onchip_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_last;
  logic [ADDR_WIDTH-1:0] m_address;
  logic [3:0]            m_byteenable;
  logic                  m_chipselect;
  logic                  m_write;
  logic [31:0]           m_writedata;
  logic [31:0]           m_readdata;
  logic                  m_clken;
  logic                  m_reset_req;

  modport master (
    input  s_data, s_valid, s_last, m_readdata,
    output s_ready, m_address, m_byteenable, m_chipselect, m_write,
           m_writedata, m_clken, m_reset_req
  );

  modport slave (
    output s_data, s_valid, s_last, m_readdata,
    input  s_ready, m_address, m_byteenable, m_chipselect, m_write,
           m_writedata, m_clken, m_reset_req
  );
endinterface

// File: rtl/minimal_onchip_loader.sv
// Packs a byte stream little-endian into 32-bit memory words, then reads the
// image back and compares the read checksum against the write checksum.
module minimal_onchip_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  minimal_onchip_loader_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    verify_ok,
  output logic                    overflow,
  output logic [ADDR_WIDTH:0]     word_count,
  output logic [31:0]             checksum
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WRITE = 3'd2,
    RD    = 3'd3,
    CMP   = 3'd4,
    FIN   = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_W   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   ZERO_W  = (ADDR_WIDTH + 1)'(0);

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, raddr_q, raddr_d;
  logic [1:0]            lane_q, lane_d;
  logic [3:0]            be_acc_q, be_acc_d, last_be_q, last_be_d;
  logic [31:0]           data_acc_q, data_acc_d, wsum_q, wsum_d, rsum_q, rsum_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  overflow_q, overflow_d, verify_ok_q, verify_ok_d;
  logic                  last_flag_q, last_flag_d;

  logic                  s_ready_s, m_cs_s, m_wr_s;
  logic [ADDR_WIDTH-1:0] m_addr_s, last_raddr_s;
  logic [3:0]            m_be_s;
  logic [31:0]           m_wdata_s, word_s;

  assign last_raddr_s = BASE_C + word_count_q[ADDR_WIDTH-1:0] - ONE_A;
  assign word_s       = data_acc_q & lane_mask(be_acc_q);

  // Next-state, datapath updates and bus outputs decoded from the current state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    raddr_d      = raddr_q;
    lane_d       = lane_q;
    be_acc_d     = be_acc_q;
    last_be_d    = last_be_q;
    data_acc_d   = data_acc_q;
    wsum_d       = wsum_q;
    rsum_d       = rsum_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    verify_ok_d  = verify_ok_q;
    last_flag_d  = last_flag_q;
    s_ready_s    = 1'b0;
    m_cs_s       = 1'b0;
    m_wr_s       = 1'b0;
    m_addr_s     = {ADDR_WIDTH{1'b0}};
    m_be_s       = 4'h0;
    m_wdata_s    = 32'h0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FILL;
          addr_d       = BASE_C;
          lane_d       = 2'd0;
          be_acc_d     = 4'h0;
          data_acc_d   = 32'h0;
          wsum_d       = 32'h0;
          rsum_d       = 32'h0;
          word_count_d = ZERO_W;
          overflow_d   = 1'b0;
          verify_ok_d  = 1'b0;
          last_flag_d  = 1'b0;
          last_be_d    = 4'h0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        s_ready_s = 1'b1;
        if (bus.s_valid && (word_count_q == DEPTH_C)) begin
          // Memory full: swallow the byte; every stored word was complete.
          overflow_d = 1'b1;
          if (bus.s_last) begin
            last_flag_d = 1'b1;
            last_be_d   = 4'hF;
            raddr_d     = BASE_C;
            if (word_count_q == ZERO_W) begin
              state_d     = FIN;
              verify_ok_d = 1'b0;
            end else begin
              state_d = RD;
            end
          end else begin
            state_d = FILL;
          end
        end else if (bus.s_valid) begin
          data_acc_d[{lane_q, 3'b000} +: 8] = bus.s_data;
          be_acc_d[lane_q]                  = 1'b1;
          lane_d                            = lane_q + 2'd1;
          if (bus.s_last) begin
            last_flag_d = 1'b1;
            last_be_d   = be_acc_d;
          end else begin
            last_flag_d = last_flag_q;
          end
          if ((lane_q == 2'd3) || bus.s_last) begin
            state_d = WRITE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      WRITE: begin
        m_cs_s       = 1'b1;
        m_wr_s       = 1'b1;
        m_addr_s     = addr_q;
        m_be_s       = be_acc_q;
        m_wdata_s    = word_s;
        wsum_d       = wsum_q + word_s;
        addr_d       = addr_q + ONE_A;
        word_count_d = word_count_q + ONE_W;
        lane_d       = 2'd0;
        be_acc_d     = 4'h0;
        data_acc_d   = 32'h0;
        if (last_flag_q) begin
          state_d = RD;
          raddr_d = BASE_C;
        end else begin
          state_d = FILL;
        end
      end
      RD: begin
        m_cs_s   = 1'b1;
        m_addr_s = raddr_q;
        m_be_s   = 4'hF;
        state_d  = CMP;
      end
      CMP: begin
        raddr_d = raddr_q + ONE_A;
        if (raddr_q == last_raddr_s) begin
          rsum_d      = rsum_q + (bus.m_readdata & lane_mask(last_be_q));
          verify_ok_d = (rsum_d == wsum_q) && !overflow_q;
          state_d     = FIN;
        end else begin
          rsum_d  = rsum_q + bus.m_readdata;
          state_d = RD;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      raddr_q      <= {ADDR_WIDTH{1'b0}};
      lane_q       <= 2'd0;
      be_acc_q     <= 4'h0;
      last_be_q    <= 4'h0;
      data_acc_q   <= 32'h0;
      wsum_q       <= 32'h0;
      rsum_q       <= 32'h0;
      word_count_q <= ZERO_W;
      overflow_q   <= 1'b0;
      verify_ok_q  <= 1'b0;
      last_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      raddr_q      <= raddr_d;
      lane_q       <= lane_d;
      be_acc_q     <= be_acc_d;
      last_be_q    <= last_be_d;
      data_acc_q   <= data_acc_d;
      wsum_q       <= wsum_d;
      rsum_q       <= rsum_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      verify_ok_q  <= verify_ok_d;
      last_flag_q  <= last_flag_d;
    end
  end

  assign bus.s_ready      = s_ready_s;
  assign bus.m_chipselect = m_cs_s;
  assign bus.m_write      = m_wr_s;
  assign bus.m_address    = m_addr_s;
  assign bus.m_byteenable = m_be_s;
  assign bus.m_writedata  = m_wdata_s;
  assign bus.m_clken      = 1'b1;
  assign bus.m_reset_req  = reset;

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign verify_ok  = verify_ok_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;
  assign checksum   = wsum_q;
endmodule

// File: tb/tb_minimal_onchip_loader.sv
// Directed and random load scenarios for minimal_onchip_loader, checked against
// an image-level model of packing, write checksum and verify outcome.
module tb_minimal_onchip_loader;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, verify_ok, overflow;
  logic [AW:0]   word_count;
  logic [31:0]   checksum;

  minimal_onchip_loader_if #(.ADDR_WIDTH(AW)) bus ();

  minimal_onchip_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .verify_ok(verify_ok), .overflow(overflow),
    .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory model, write log and done-pulse counter.
  logic [31:0]   mem [1024];
  logic [31:0]   rd_q = 32'h0;
  int            corrupt_word = -1;
  logic          fill_req = 1'b0;
  logic [31:0]   fill_val = 32'h0;
  logic [AW-1:0] log_addr [64];
  logic [3:0]    log_be   [64];
  logic [31:0]   log_data [64];
  int            wr_cnt   = 0;
  int            done_cnt = 0;
  logic [7:0]    img [$];

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 8; i++) mem[i] <= fill_val ^ 32'(i);
    end else if (bus.m_chipselect && bus.m_write) begin
      for (int k = 0; k < 4; k++)
        if (bus.m_byteenable[k]) mem[bus.m_address][8*k +: 8] <= bus.m_writedata[8*k +: 8];
      log_addr[wr_cnt % 64] <= bus.m_address;
      log_be[wr_cnt % 64]   <= bus.m_byteenable;
      log_data[wr_cnt % 64] <= bus.m_writedata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.m_chipselect)
      rd_q <= mem[bus.m_address] ^ ((int'(bus.m_address) == corrupt_word) ? 32'h1 : 32'h0);
    if (done) done_cnt <= done_cnt + 1;
  end

  assign bus.m_readdata = rd_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input logic [31:0] v);
    fill_val = v;
    fill_req = 1'b1;
    @(posedge clk); #1;
    fill_req = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic last);
    int guard;
    guard = 0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    @(negedge clk);
    while (!bus.s_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 64'(guard < 40), 64'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic load_seq(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'(i + 1));
  endtask

  // Drives the current image and checks every write and the final status
  // against expectations derived from the byte list alone.
  task automatic run_load(input string tag, input bit toggle, input bit poke_start, input int corrupt);
    int          n, nw, wn, wr0, dn0, guard;
    bit          ovf, exp_ok;
    logic [31:0] wdata [DEPTH];
    logic [3:0]  wbe   [DEPTH];
    logic [31:0] sum;
    corrupt_word = corrupt;
    n   = img.size();
    nw  = (n + 3) / 4;
    ovf = (nw > DEPTH);
    wn  = ovf ? DEPTH : nw;
    sum = 32'h0;
    for (int w = 0; w < wn; w++) begin
      wdata[w] = 32'h0;
      wbe[w]   = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) begin
          wdata[w] = wdata[w] | (32'(img[4*w+k]) << (8 * k));
          wbe[w][k] = 1'b1;
        end
      end
      sum = sum + wdata[w];
    end
    exp_ok = !ovf && !(corrupt >= 0 && corrupt < wn);
    wr0 = wr_cnt;
    dn0 = done_cnt;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      push(img[i], i == n - 1);
      if (poke_start && i == 3) begin
        check({tag, "_busy_at_poke"}, 64'(busy), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (toggle) begin
        @(posedge clk); #1;
      end
    end

    guard = 0;
    @(negedge clk);
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    check({tag, "_word_count"}, 64'(word_count), 64'(wn));
    check({tag, "_overflow"}, 64'(overflow), 64'(ovf));
    check({tag, "_checksum"}, 64'(checksum), 64'(sum));
    check({tag, "_verify_ok"}, 64'(verify_ok), 64'(exp_ok));

    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - dn0), 64'd1);
    check({tag, "_writes"}, 64'(wr_cnt - wr0), 64'(wn));
    check({tag, "_verify_held"}, 64'(verify_ok), 64'(exp_ok));
    check({tag, "_idle"}, 64'({busy, done, bus.s_ready, bus.m_chipselect}), 64'd0);
    for (int w = 0; w < wn; w++) begin
      check($sformatf("%s_w%0d_addr", tag, w), 64'(log_addr[(wr0 + w) % 64]), 64'(w));
      check($sformatf("%s_w%0d_be", tag, w), 64'(log_be[(wr0 + w) % 64]), 64'(wbe[w]));
      check($sformatf("%s_w%0d_data", tag, w), 64'(log_data[(wr0 + w) % 64]), 64'(wdata[w]));
    end
    corrupt_word = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reset_req"}, 64'(bus.m_reset_req), 64'd1);
    check({tag, "_clken"}, 64'(bus.m_clken), 64'd1);
    check({tag, "_flags"}, 64'({busy, done, verify_ok, overflow, bus.s_ready,
                                bus.m_chipselect, bus.m_write}), 64'd0);
    check({tag, "_bus"}, 64'({bus.m_address, bus.m_byteenable}), 64'd0);
    check({tag, "_wdata"}, 64'(bus.m_writedata), 64'd0);
    check({tag, "_counts"}, 64'({word_count, checksum}), 64'd0);
  endtask

  initial begin
    int wr_before, dn_before, n;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_req_low", 64'(bus.m_reset_req), 64'd0);
    check("clken_high", 64'(bus.m_clken), 64'd1);

    // 1: eight sequential bytes
    load_seq(8);
    run_load("t1", 1'b0, 1'b0, -1);
    check("t1_checksum_const", 64'(checksum), 64'h0C0A0806);

    // 2: partial last word over junk memory
    fill_mem(32'hFFFF_FFFF);
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load("t2", 1'b0, 1'b0, -1);
    check("t2_w1_const", 64'(log_data[(wr_cnt - 1) % 64]), 64'h0000_00EE);

    // 3: corrupted readback of word 1
    load_seq(8);
    run_load("t3", 1'b0, 1'b0, 1);

    // 4: overflow past DEPTH
    load_seq(20);
    run_load("t4", 1'b0, 1'b0, -1);

    // 5: reset in the middle of FILL
    wr_before = wr_cnt;
    dn_before = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    reset = 1'b1;
    #1;
    check("t5_reset_req_comb", 64'(bus.m_reset_req), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t5");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_no_write", 64'(wr_cnt - wr_before), 64'd0);
    check("t5_no_done", 64'(done_cnt - dn_before), 64'd0);
    load_seq(8);
    run_load("t5_reload", 1'b0, 1'b0, -1);

    // 6: gappy valid and a start pulse during WRITE
    load_seq(8);
    run_load("t6", 1'b1, 1'b1, -1);

    // Random images, gaps and corruption
    for (int r = 0; r < 16; r++) begin
      fill_mem($urandom);
      n = $urandom_range(1, 22);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
      run_load($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'b0,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/minimal_onchip_loader.md
Name: minimal_onchip_loader

Overview:
- Upstream stage for the single-port 32-bit on-chip memory.
- Accepts a byte stream with a valid/ready handshake, such as from a JTAG or UART boot source.
- Packs the bytes little-endian into 32-bit words and writes them sequentially from BASE_ADDR.
- After the last byte, reads the image back and compares checksums, then reports done and verify_ok to the system controller.

Parameters:
- ADDR_WIDTH, 10: memory word-address width.
- DEPTH, 1024: number of memory words; writes beyond this are dropped.
- BASE_ADDR, 0: first word address written and verified.

Ports:
- clk  in  1: single clock; memory shares it.
- reset  in  1: synchronous, active-high.
- start  in  1: 1-cycle pulse; begins a load. Ignored while busy.
- s_data  in  8: stream byte.
- s_valid  in  1: s_data is valid.
- s_ready  out  1: loader accepts a byte this cycle.
- s_last  in  1: qualifies the final byte of the image.
- m_address  out  ADDR_WIDTH: memory word address.
- m_byteenable  out  4: memory lane enables.
- m_chipselect  out  1: memory select.
- m_write  out  1: memory write strobe.
- m_writedata  out  32: memory write data.
- m_readdata  in  32: memory read data; valid 1 cycle after the address is presented.
- m_clken  out  1: memory clock enable.
- m_reset_req  out  1: memory reset request.
- busy  out  1: high in any state other than IDLE.
- done  out  1: 1-cycle pulse at the end of verify.
- verify_ok  out  1: result of the last load; held until the next start.
- overflow  out  1: sticky; set when bytes were dropped past DEPTH.
- word_count  out  ADDR_WIDTH+1: number of words written in this load.
- checksum  out  32: write checksum.

Behaviour:
Reset and constant outputs:
- On reset, all outputs are 0 except m_reset_req and m_clken.
- m_reset_req = reset, combinational. m_clken = 1 at all times.
- Reset in any state forces IDLE next cycle and clears all counters, sums and flags. A partially packed word is discarded and no memory write is issued.

State machine (IDLE, FILL, WRITE, RD, CMP, FIN):
- IDLE: s_ready=0, m_chipselect=0.
  - start=1 -> FILL. Also loads addr=BASE_ADDR, lane=0, be_acc=0, wsum=0, rsum=0, word_count=0, overflow=0, verify_ok=0.
- FILL: s_ready=1.
  - On s_valid&s_ready: data_acc[8*lane+:8] = s_data; be_acc[lane] = 1; lane++.
  - If lane==3 or s_last: go to WRITE; s_ready=0 from the next cycle.
  - If s_last: set last_flag and latch last_be = updated be_acc.
  - If word_count==DEPTH, accepted bytes are discarded and overflow=1. s_last then goes directly to RD (no WRITE).
- WRITE: exactly one cycle.
  - Drives m_chipselect=1, m_write=1, m_address=addr, m_byteenable=be_acc, m_writedata=data_acc. Unenabled lanes of m_writedata are 0.
  - Updates wsum += data_acc, modulo 2^32, unenabled lanes zero.
  - Increments addr and word_count. Clears lane, be_acc and data_acc.
  - Next state is RD (raddr=BASE_ADDR) if last_flag, else FILL.
- RD: m_chipselect=1, m_write=0, m_address=raddr, m_byteenable=4'hF. Go to CMP.
- CMP: sample m_readdata.
  - Mask with last_be if raddr is the final word, else 4'hF.
  - rsum += masked value. raddr++.
  - If raddr was the final word (BASE_ADDR+word_count-1) -> FIN, else RD.
  - With word_count==0 (overflow-only case), RD/CMP are skipped: go straight to FIN.
- FIN: done=1 for one cycle; verify_ok = (rsum==wsum) & ~overflow. Go to IDLE.

Other rules:
- Throughput: 4 bytes per 5 cycles in FILL/WRITE; 2 cycles per word in verify.
- checksum = wsum, continuously.
- A start during busy has no effect.
- s_last on lane 0 produces a write with byteenable 4'h1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. This is never reached because DEPTH limits word_count.

Test Plan:
1. Reset, start, then 8 bytes 0x01..0x08 with s_last on 0x08.
   - Writes: addr0 = 0x04030201 with be F; addr1 = 0x08070605 with be F.
   - word_count=2, checksum=0x0C0A0806, done pulse, verify_ok=1.
2. 5 bytes 0xAA,0xBB,0xCC,0xDD,0xEE with s_last on 0xEE.
   - Second write is 0x000000EE with be=4'h1.
   - Readback of that word is masked; verify_ok=1 even if the memory upper lanes are nonzero.
3. Memory model corrupts word 1 on readback (bit 0 flipped) -> verify_ok=0, done still pulses once.
4. DEPTH=4, stream of 20 bytes.
   - Exactly 4 writes occur; overflow=1, word_count=4, verify_ok=0.
5. Reset asserted mid-FILL after 2 bytes.
   - No memory write occurs; outputs return to 0 and m_reset_req=1 during reset.
   - A fresh start then loads correctly.
6. s_valid toggling every other cycle, plus a start pulse during WRITE.
   - Same memory contents as scenario 1; the start is ignored and only one done pulse occurs.
